// File: rtl/draw_pkg.sv
// Shared screen geometry, command word layouts and FSM state encoding
// for the rectangle rasterizer.
package draw_pkg;

  localparam int SCREEN_WIDTH  = 640;
  localparam int SCREEN_HEIGHT = 480;
  localparam int DATA_WIDTH    = 22;
  localparam int COLOR_WIDTH   = 3;
  localparam int FB_ADDR_WIDTH = $clog2(SCREEN_WIDTH * SCREEN_HEIGHT);
  localparam int DIM_WIDTH     = 11;

  localparam logic [DIM_WIDTH-1:0]     SCREEN_W_DIM = DIM_WIDTH'(SCREEN_WIDTH);
  localparam logic [DIM_WIDTH-1:0]     SCREEN_H_DIM = DIM_WIDTH'(SCREEN_HEIGHT);
  localparam logic [FB_ADDR_WIDTH-1:0] ROW_STRIDE   = FB_ADDR_WIDTH'(SCREEN_WIDTH);

  typedef struct packed {
    logic [COLOR_WIDTH-1:0] colour;
    logic [8:0]             y;
    logic [9:0]             x;
  } rect_hdr_t;

  typedef struct packed {
    logic [2:0] reserved;
    logic [8:0] height;
    logic [9:0] width;
  } rect_size_t;

  typedef struct packed {
    logic                 drop;
    logic [DIM_WIDTH-1:0] w_eff;
    logic [DIM_WIDTH-1:0] h_eff;
  } clip_t;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_HDR      = 3'd1,
    ST_REQ_SIZE = 3'd2,
    ST_SIZE     = 3'd3,
    ST_DRAW     = 3'd4
  } rast_state_e;

endpackage

// File: rtl/rect_rasterizer_if.sv
// Command FIFO read side and framebuffer write port of the rasterizer.
interface rect_rasterizer_if;
  import draw_pkg::*;

  logic                     fifo_empty;
  logic                     fifo_rd_en;
  logic [DATA_WIDTH-1:0]    fifo_rd_data;
  logic                     fb_wr_en;
  logic                     fb_wr_ready;
  logic [FB_ADDR_WIDTH-1:0] fb_wr_addr;
  logic [COLOR_WIDTH-1:0]   fb_wr_data;

  modport master (
    input  fifo_empty,
    output fifo_rd_en,
    input  fifo_rd_data,
    output fb_wr_en,
    input  fb_wr_ready,
    output fb_wr_addr,
    output fb_wr_data
  );

  modport slave (
    output fifo_empty,
    input  fifo_rd_en,
    output fifo_rd_data,
    input  fb_wr_en,
    output fb_wr_ready,
    input  fb_wr_addr,
    input  fb_wr_data
  );

endinterface

// File: rtl/rect_rasterizer.sv
// Pops two-word rectangle commands, clips them to the screen and emits one
// framebuffer write per covered pixel in row-major order.
module rect_rasterizer
  import draw_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              ce,
  rect_rasterizer_if.master bus,
  output logic              busy,
  output logic              cmd_dropped
);

  rast_state_e              state_q;
  rect_hdr_t                hdr_q;
  logic [DIM_WIDTH-1:0]     w_eff_q;
  logic [DIM_WIDTH-1:0]     h_eff_q;
  logic [DIM_WIDTH-1:0]     col_q;
  logic [DIM_WIDTH-1:0]     row_q;
  logic [FB_ADDR_WIDTH-1:0] row_base_q;
  logic [FB_ADDR_WIDTH-1:0] addr_q;
  logic [COLOR_WIDTH-1:0]   data_q;
  logic                     wr_en_q;
  logic                     busy_q;
  logic                     dropped_q;

  rect_size_t               size_s;
  clip_t                    clip_d;
  logic [FB_ADDR_WIDTH-1:0] row_base_init_d;
  logic [FB_ADDR_WIDTH-1:0] row_base_next_d;
  logic                     last_col_s;
  logic                     last_row_s;
  logic                     unused_s;

  // All arithmetic is 11-bit so SCREEN - x and the min() cannot wrap.
  function automatic clip_t clip_rect(input rect_hdr_t hdr, input rect_size_t size);
    logic [DIM_WIDTH-1:0] x_v;
    logic [DIM_WIDTH-1:0] y_v;
    logic [DIM_WIDTH-1:0] w_v;
    logic [DIM_WIDTH-1:0] h_v;
    logic [DIM_WIDTH-1:0] room_w_v;
    logic [DIM_WIDTH-1:0] room_h_v;
    clip_t                res_v;
    x_v      = {1'b0, hdr.x};
    y_v      = {2'b00, hdr.y};
    w_v      = {1'b0, size.width};
    h_v      = {2'b00, size.height};
    room_w_v = SCREEN_W_DIM - x_v;
    room_h_v = SCREEN_H_DIM - y_v;
    res_v.drop  = (x_v >= SCREEN_W_DIM) || (y_v >= SCREEN_H_DIM) ||
                  (w_v == 11'd0) || (h_v == 11'd0);
    res_v.w_eff = (w_v < room_w_v) ? w_v : room_w_v;
    res_v.h_eff = (h_v < room_h_v) ? h_v : room_h_v;
    return res_v;
  endfunction

  assign size_s   = rect_size_t'(bus.fifo_rd_data);
  assign unused_s = ^size_s.reserved;

  // Clipping, start address and per-row stepping decoded from current state.
  always_comb begin
    clip_d          = clip_rect(hdr_q, size_s);
    row_base_init_d = ({10'd0, hdr_q.y} * ROW_STRIDE) + {9'd0, hdr_q.x};
    row_base_next_d = row_base_q + ROW_STRIDE;
    last_col_s      = (col_q == (w_eff_q - 11'd1));
    last_row_s      = (row_q == (h_eff_q - 11'd1));
  end

  // Pop request is combinational so a pop completes in the same cycle it is asked for.
  always_comb begin
    bus.fifo_rd_en = 1'b0;
    if ((state_q == ST_IDLE) || (state_q == ST_REQ_SIZE)) begin
      bus.fifo_rd_en = !bus.fifo_empty;
    end else begin
      bus.fifo_rd_en = 1'b0;
    end
  end

  // Command FSM with registered write port, busy and drop pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      hdr_q      <= '0;
      w_eff_q    <= 11'd0;
      h_eff_q    <= 11'd0;
      col_q      <= 11'd0;
      row_q      <= 11'd0;
      row_base_q <= 19'd0;
      addr_q     <= 19'd0;
      data_q     <= 3'd0;
      wr_en_q    <= 1'b0;
      busy_q     <= 1'b0;
      dropped_q  <= 1'b0;
    end else if (ce) begin
      dropped_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (bus.fifo_rd_en) begin
            state_q <= ST_HDR;
            busy_q  <= 1'b1;
          end
        end
        ST_HDR: begin
          hdr_q   <= rect_hdr_t'(bus.fifo_rd_data);
          state_q <= ST_REQ_SIZE;
        end
        ST_REQ_SIZE: begin
          if (bus.fifo_rd_en) begin
            state_q <= ST_SIZE;
          end
        end
        ST_SIZE: begin
          if (clip_d.drop) begin
            dropped_q <= 1'b1;
            busy_q    <= 1'b0;
            state_q   <= ST_IDLE;
          end else begin
            w_eff_q    <= clip_d.w_eff;
            h_eff_q    <= clip_d.h_eff;
            col_q      <= 11'd0;
            row_q      <= 11'd0;
            row_base_q <= row_base_init_d;
            addr_q     <= row_base_init_d;
            data_q     <= hdr_q.colour;
            wr_en_q    <= 1'b1;
            state_q    <= ST_DRAW;
          end
        end
        ST_DRAW: begin
          if (bus.fb_wr_ready) begin
            if (last_col_s) begin
              col_q      <= 11'd0;
              row_q      <= row_q + 11'd1;
              row_base_q <= row_base_next_d;
              addr_q     <= row_base_next_d;
              if (last_row_s) begin
                wr_en_q <= 1'b0;
                busy_q  <= 1'b0;
                state_q <= ST_IDLE;
              end
            end else begin
              col_q  <= col_q + 11'd1;
              addr_q <= addr_q + 19'd1;
            end
          end
        end
        default: begin
          wr_en_q <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.fb_wr_en   = wr_en_q;
  assign bus.fb_wr_addr = addr_q;
  assign bus.fb_wr_data = data_q;
  assign busy           = busy_q;
  assign cmd_dropped    = dropped_q;

endmodule

// File: tb/tb_rect_rasterizer.sv
// Self-checking bench: behavioural FIFO, pixel monitor and a reference model
// that enumerates every rectangle pixel and keeps those lying on screen.
module tb_rect_rasterizer;
  import draw_pkg::*;

  logic clk = 1'b0;
  logic rst;
  logic ce;
  logic busy;
  logic cmd_dropped;

  rect_rasterizer_if bus ();

  rect_rasterizer dut (
    .clk         (clk),
    .rst         (rst),
    .ce          (ce),
    .bus         (bus),
    .busy        (busy),
    .cmd_dropped (cmd_dropped)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  logic [21:0] fq[$];
  int          got[$];
  int          exp_q[$];
  int          drops;
  int          exp_drops;
  int          cyc = 0;
  int          first_en;
  bit          rand_ready = 1'b0;
  bit          rand_ce = 1'b0;
  bit          stalled = 1'b0;
  logic [18:0] st_addr;
  logic [2:0]  st_data;

  task automatic chk(input logic [31:0] obs, input logic [31:0] expv, input string tag);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  function automatic logic [21:0] mk_word(input int lo, input int mid, input int hi);
    logic [21:0] w;
    w = {hi[2:0], mid[8:0], lo[9:0]};
    return w;
  endfunction

  // Reference: walk the whole requested rectangle, keep on-screen pixels.
  task automatic model_add(input int x, input int y, input int w, input int h, input int c);
    for (int r = 0; r < h; r++) begin
      for (int k = 0; k < w; k++) begin
        if ((x + k) < SCREEN_WIDTH && (y + r) < SCREEN_HEIGHT)
          exp_q.push_back(((y + r) * SCREEN_WIDTH + (x + k)) * 8 + c);
      end
    end
    if (exp_q.size() == 0 || w == 0 || h == 0 || x >= SCREEN_WIDTH || y >= SCREEN_HEIGHT)
      if (w == 0 || h == 0 || x >= SCREEN_WIDTH || y >= SCREEN_HEIGHT) exp_drops++;
  endtask

  task automatic push(input logic [21:0] w);
    fq.push_back(w);
    bus.fifo_empty = 1'b0;
  endtask

  task automatic push_cmd(input int x, input int y, input int c, input int w, input int h);
    push(mk_word(x, y, c));
    push(mk_word(w, h, int'($urandom_range(0, 7))));
    model_add(x, y, w, h, c);
  endtask

  task automatic clear_model();
    exp_q.delete();
    got.delete();
    drops = 0;
    exp_drops = 0;
  endtask

  // One clock: observe at negedge, update FIFO and inputs just after posedge.
  task automatic tick();
    bit pop;
    @(negedge clk);
    if (!rst && bus.fb_wr_en) begin
      if (stalled) begin
        chk(32'(bus.fb_wr_addr), 32'(st_addr), "stall_addr");
        chk(32'(bus.fb_wr_data), 32'(st_data), "stall_data");
      end
      if (ce && bus.fb_wr_ready) begin
        got.push_back(int'(bus.fb_wr_addr) * 8 + int'(bus.fb_wr_data));
        stalled = 1'b0;
      end else begin
        stalled = 1'b1;
        st_addr = bus.fb_wr_addr;
        st_data = bus.fb_wr_data;
      end
    end else begin
      stalled = 1'b0;
    end
    if (!rst && ce && cmd_dropped) drops++;
    pop = !rst && ce && bus.fifo_rd_en && !bus.fifo_empty;
    @(posedge clk);
    #1;
    cyc++;
    if (rst) fq.delete();
    else if (pop) bus.fifo_rd_data = fq.pop_front();
    bus.fifo_empty  = (fq.size() == 0);
    bus.fb_wr_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    ce              = rand_ce ? ((cyc % 4) != 0) : 1'b1;
  endtask

  task automatic wait_done();
    int n = 0;
    first_en = -1;
    while ((busy || fq.size() != 0) && n < 3000) begin
      tick();
      n++;
      if (first_en < 0 && bus.fb_wr_en) first_en = n;
    end
    chk(32'(n < 3000), 32'd1, "timeout");
    tick();
    tick();
    chk(32'(bus.fb_wr_en), 32'd0, "wr_en_after");
    chk(32'(busy), 32'd0, "busy_after");
  endtask

  task automatic compare(input string tag);
    chk(32'(got.size()), 32'(exp_q.size()), {tag, "_count"});
    for (int i = 0; i < got.size() && i < exp_q.size(); i++)
      chk(32'(got[i]), 32'(exp_q[i]), {tag, "_pixel"});
    chk(32'(drops), 32'(exp_drops), {tag, "_drops"});
  endtask

  initial begin
    int x;
    int y;
    int n;
    rst              = 1'b1;
    ce               = 1'b1;
    bus.fifo_empty   = 1'b1;
    bus.fifo_rd_data = 22'd0;
    bus.fb_wr_ready  = 1'b1;
    clear_model();
    repeat (3) tick();
    rst = 1'b0;
    tick();
    chk(32'(bus.fb_wr_en), 32'd0, "rst_wr_en");
    chk(32'(bus.fb_wr_addr), 32'd0, "rst_addr");
    chk(32'(bus.fb_wr_data), 32'd0, "rst_data");
    chk(32'(busy), 32'd0, "rst_busy");
    chk(32'(cmd_dropped), 32'd0, "rst_dropped");
    chk(32'(bus.fifo_rd_en), 32'd0, "rst_rd_en");

    // Basic 3x2 rectangle, also checks header-to-first-write latency.
    clear_model();
    push_cmd(10, 20, 5, 3, 2);
    wait_done();
    chk(32'(first_en), 32'd4, "latency");
    chk(32'(got.size() > 0 ? got[0] : -1), 32'(12810 * 8 + 5), "basic_first");
    compare("basic");

    clear_model();
    push_cmd(638, 479, 6, 5, 4);
    wait_done();
    compare("corner_clip");

    // Dropped commands followed by a normal one.
    clear_model();
    push_cmd(700, 33, 2, 4, 4);
    push_cmd(5, 6, 3, 0, 4);
    push_cmd(1, 2, 7, 2, 2);
    wait_done();
    compare("drop");

    // Size word arriving late.
    clear_model();
    push(mk_word(100, 200, 4));
    repeat (10) tick();
    chk(32'(busy), 32'd1, "wait_busy");
    chk(32'(bus.fifo_rd_en), 32'd0, "wait_rd_en");
    push(mk_word(2, 3, 0));
    model_add(100, 200, 2, 3, 4);
    wait_done();
    compare("late_size");

    // Backpressure and clock-enable gaps.
    clear_model();
    rand_ready = 1'b1;
    rand_ce    = 1'b1;
    push_cmd(300, 100, 1, 4, 3);
    wait_done();
    compare("stall");
    rand_ready = 1'b0;
    rand_ce    = 1'b0;
    tick();

    // Reset while the third pixel is presented.
    clear_model();
    push_cmd(100, 50, 3, 4, 4);
    n = 0;
    while (!(got.size() == 2 && bus.fb_wr_en) && n < 200) begin
      tick();
      n++;
    end
    chk(32'(n < 200), 32'd1, "rst_mid_reach");
    rst = 1'b1;
    tick();
    chk(32'(bus.fb_wr_en), 32'd0, "rst_mid_wr_en");
    chk(32'(busy), 32'd0, "rst_mid_busy");
    chk(32'(got.size()), 32'd2, "rst_mid_count");
    rst = 1'b0;
    tick();
    clear_model();
    push_cmd(0, 0, 6, 2, 2);
    wait_done();
    compare("after_rst");

    // Randomized commands near and away from the screen edges.
    rand_ready = 1'b1;
    for (int i = 0; i < 25; i++) begin
      clear_model();
      rand_ce = 1'($urandom_range(0, 1));
      x = ($urandom_range(0, 1) != 0) ? int'($urandom_range(0, 639)) : int'($urandom_range(620, 1023));
      y = ($urandom_range(0, 1) != 0) ? int'($urandom_range(0, 479)) : int'($urandom_range(470, 511));
      push_cmd(x, y, int'($urandom_range(0, 7)), int'($urandom_range(0, 12)), int'($urandom_range(0, 5)));
      wait_done();
      compare("random");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rect_rasterizer.md
Name: rect_rasterizer

Overview:
Downstream consumer of the 22-bit draw-command FIFO. It pops two-word rectangle commands, clips each rectangle to the screen, and emits one framebuffer pixel write per covered pixel in row-major order. Writes use a valid/ready handshake towards the framebuffer write port. The block sits between the command FIFO and the framebuffer.

Parameters:
SCREEN_WIDTH, 640, pixels per row
SCREEN_HEIGHT, 480, rows
DATA_WIDTH, 22, FIFO word width; fixed by the command format
COLOR_WIDTH, 3, pixel colour bits
FB_ADDR_WIDTH, $clog2(SCREEN_WIDTH*SCREEN_HEIGHT) = 19, framebuffer address width

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high; one clock; takes priority over ce
ce  in  1  clock enable; no state changes while low
fifo_empty  in  1  FIFO empty flag
fifo_rd_en  out  1  FIFO pop request
fifo_rd_data  in  DATA_WIDTH  FIFO read data; registered; valid the cycle after an accepted pop, held otherwise
fb_wr_en  out  1  pixel write valid
fb_wr_ready  in  1  framebuffer accepts write
fb_wr_addr  out  FB_ADDR_WIDTH  y*SCREEN_WIDTH + x
fb_wr_data  out  COLOR_WIDTH  pixel colour
busy  out  1  high in any state except IDLE
cmd_dropped  out  1  one-cycle pulse when a command is fully clipped away

Behaviour:
- Command word 0 (header): [9:0] x, [18:10] y, [21:19] colour.
- Command word 1 (size): [9:0] width, [18:10] height, [21:19] reserved and ignored.
- A pop is accepted when fifo_rd_en && !fifo_empty && ce. fifo_rd_en is combinational: it is high only in IDLE or REQ_SIZE while !fifo_empty.
- The popped word is sampled from fifo_rd_data in the next ce cycle.
- States (all transitions happen only on ce=1):
  - IDLE: if !fifo_empty, pop and go to HDR.
  - HDR: latch x, y and colour, then go to REQ_SIZE.
  - REQ_SIZE: if !fifo_empty, pop and go to SIZE; otherwise wait here with no timeout.
  - SIZE: latch the size and evaluate clipping in the same cycle.
    - Drop the command if x>=SCREEN_WIDTH, y>=SCREEN_HEIGHT, width==0 or height==0. On a drop, pulse cmd_dropped for one cycle and return to IDLE.
    - Otherwise clip: w_eff = min(width, SCREEN_WIDTH-x), h_eff = min(height, SCREEN_HEIGHT-y).
    - Load row_base = y*SCREEN_WIDTH + x and go to DRAW.
  - DRAW: fb_wr_en=1 with the current address and colour.
    - A write transfers when fb_wr_en && fb_wr_ready && ce.
    - On transfer, the column counter increments and the address increments by 1.
    - At column w_eff-1: the column resets to 0, row_base += SCREEN_WIDTH, the address takes the new row_base, and the row increments.
    - The transfer at the last row and last column returns to IDLE. fb_wr_en is low in the following cycle.
- Address arithmetic: use no multiplier in the per-pixel path. The y*SCREEN_WIDTH in SIZE may be a constant multiply. Width and height arithmetic is 11-bit so min() cannot overflow.
- Backpressure: while fb_wr_ready is low, fb_wr_addr and fb_wr_data hold stable and fb_wr_en stays high.
- ce low: fb_wr_en and the address hold their values; no transfer and no pop counts.
- The minimum latency from header pop to first pixel write is 3 ce cycles (HDR, REQ_SIZE, SIZE), plus 1 if the size word pops in a later cycle.
- Reset values: state IDLE, fifo_rd_en 0, fb_wr_en 0, fb_wr_addr 0, fb_wr_data 0, busy 0, cmd_dropped 0.
- Reset mid-DRAW: the current command is abandoned and no further writes are issued. FIFO words already popped are lost; the FIFO is reset alongside this block.
- A header whose size word never arrives leaves busy high. This is intentional; the producer always pushes commands in pairs.

Decomposition:
- Shared package draw_pkg holds:
  - SCREEN_WIDTH, SCREEN_HEIGHT and COLOR_WIDTH constants.
  - Packed struct typedefs rect_hdr_t {colour, y, x} and rect_size_t {reserved, height, width}, each 22 bits.
  - The state enum typedef.
- No sub-module: a single FSM plus counters. Clipping stays as an inline function.

Test Plan:
- Header x=10,y=20,colour=5, then size w=3,h=2 -> exactly 6 writes: addrs 12810,12811,12812,13450,13451,13452, all data 5. busy falls after the last write and cmd_dropped stays 0.
- Header x=638,y=479, size w=5,h=4 -> clipped to 2x1: writes 307198 and 307199 only.
- Header x=700 (any y), or size w=0 -> no writes, one cmd_dropped pulse, return to IDLE. The next queued command is processed normally.
- Header pushed, size pushed 10 cycles later -> block waits in REQ_SIZE with busy=1 and fifo_rd_en=0. Drawing then proceeds with correct addresses.
- fb_wr_ready toggled randomly and ce low 1 cycle in 4 during a 4x3 rect -> 12 transfers with no duplicates or skips, and addr/data stable while stalled.
- rst asserted on the 3rd pixel of a 4x4 rect -> next cycle fb_wr_en=0, busy=0. After rst releases, a new command draws correctly from its first pixel.
